i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target (responder) with a byte-addressed register port, sitting on the FPGA side of the board's open-drain I2C bus opposite the SoC's I2C controller. It lets the on-chip controller, or an external one, read and write a bank of up to 256 8-bit registers through standard pointer-then-data transactions. It samples SCL/SDA on `sys_clk` and drives SDA low only for ACK and read-data zeros. It never stretches SCL.

## Interface
- `ADDR` — default 7'h42 — 7-bit target address.
- `FILT_LEN` — default 3 — consecutive equal samples required before a filtered SCL/SDA level changes (≥1).

- `sys_clk` in 1 — sole clock.
- `sys_rst` in 1 — synchronous, active-high reset.
- `scl_i` in 1 — raw SCL pad level (asynchronous).
- `sda_i` in 1 — raw SDA pad level (asynchronous).
- `sda_o` out 1 — 1 = release (pad Z), 0 = pull low.
- `reg_addr` out 8 — current register pointer.
- `reg_wdata` out 8 — write data, valid while `reg_we`=1.
- `reg_we` out 1 — one-cycle write strobe.
- `reg_re` out 1 — one-cycle read request for `reg_addr`.
- `reg_rdata` in 8 — read data, sampled the cycle after `reg_re`.
- `busy` out 1 — 1 from an address match until STOP, START, or NACK.

## Operation
- Input path: 2-flop synchronizer, then a FILT_LEN-sample majority-free run filter. Edge detect operates on the filtered levels only.
- START: filtered SDA falls while filtered SCL is high. STOP: filtered SDA rises while filtered SCL is high. Both are recognised in every state and take priority over bit events.
- Bits are sampled on filtered SCL rise. `sda_o` changes only in the cycle after a filtered SCL fall.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits MSB first.
    - If bits[7:1]==ADDR: go to ADDR_ACK.
    - Otherwise: go to IGNORE.
  - ADDR_ACK: drive 0 for one bit.
    - If R/W=0: go to PTR.
    - If R/W=1: issue prefetch (see below), then go to RDATA.
  - PTR: 8 bits into the pointer → PTR_ACK (drive 0) → WDATA.
  - WDATA: 8 bits. In the cycle after the 8th rise: `reg_we`=1, `reg_addr`=ptr, `reg_wdata`=byte. The pointer increments the following cycle. Then WDATA_ACK (drive 0) → WDATA.
  - RDATA: shift out 8 bits MSB first → RACK, with SDA released.
    - Sample the controller's bit on SCL rise. ACK (0): prefetch, then RDATA. NACK (1): IGNORE.
  - IGNORE: SDA released; wait for START (→ADDR) or STOP (→IDLE).
- Prefetch:
  - On the SCL fall ending ADDR_ACK or an ACKed RACK, pulse `reg_re` for one cycle with `reg_addr`=ptr.
  - Next cycle: load `reg_rdata` into the shift register, drive its MSB on `sda_o`, and increment the pointer.
- Pointer: 8-bit, wraps 0xFF→0x00. It persists across transactions and is cleared only by reset. A repeated START keeps the pointer, so write-pointer, Sr, read works.
- A STOP or START mid-byte discards the partial byte: no `reg_we`, SDA released.
- Writes are always ACKed. The address byte is ACKed only on a match. A general call (0x00) is not matched.

## Timing
- Reset values: `sda_o`=1, `reg_we`=0, `reg_re`=0, `busy`=0, `reg_addr`=0x00, `reg_wdata`=0x00, state IDLE, filters preset to 1.
- Reset mid-transaction: `sda_o`=1 on the first edge with `sys_rst`=1. After reset, the block responds only after a new START.
- Input latency: pad to filtered level is 2+FILT_LEN cycles.
- `sda_o` update: 1 cycle after a filtered SCL fall, or 2 cycles on a prefetch.
- Required clock ratio: `sys_clk` ≥ 16× SCL, with FILT_LEN+4 cycles < SCL low time.
- `reg_we` and `reg_re` are never high in the same cycle. Each is exactly one cycle per byte.

## Test plan
- Write: START, 0x84, 0x10, 0xA5, 0x5A, STOP → four ACKs; `reg_we` pulses (0x10,0xA5) then (0x11,0x5A); `reg_addr`=0x12 after; `busy` falls at STOP.
- Read with Sr: START, 0x84, 0x10, Sr, 0x85, controller ACKs byte 1 and NACKs byte 2, STOP, with model mem[0x10]=0xC3, mem[0x11]=0x3C → SDA carries 0xC3 then 0x3C; exactly two `reg_re` pulses; SDA released after the NACK.
- Mismatch: START, 0x86, 0x00, STOP → SDA never low, no `reg_we`, `busy`=0 throughout.
- Wrap: write with pointer 0xFF and data 0x11, 0x22 → writes at 0xFF then 0x00.
- Glitches: a 1-cycle SDA low pulse while SCL is high (shorter than FILT_LEN), and a 1-cycle SCL pulse → no START/STOP, no state change.
- Reset during RDATA while `sda_o`=0 → `sda_o`=1 the next cycle; a following clean write transaction completes correctly.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-addressed register port through pointer-then-data transactions.
// SCL/SDA are oversampled on sys_clk, run-length filtered, and SDA is driven only for ACK and read zeros.
module i2c_target_regs #(
    parameter logic [6:0] ADDR     = 7'h42,
    parameter int         FILT_LEN = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
    } state_t;

    logic [1:0]    scl_s, sda_s;
    logic          scl_f, sda_f, scl_q, sda_q;
    logic [CW-1:0] scl_cnt, sda_cnt;

    // A filtered level flips only after FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scl_s   <= 2'b11;
            sda_s   <= 2'b11;
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_s <= {scl_s[0], scl_i};
            sda_s <= {sda_s[0], sda_i};
            scl_q <= scl_f;
            sda_q <= sda_f;
            if (scl_s[1] == scl_f) scl_cnt <= '0;
            else if (scl_cnt == CNT_MAX) begin
                scl_f   <= scl_s[1];
                scl_cnt <= '0;
            end else scl_cnt <= scl_cnt + 1'b1;
            if (sda_s[1] == sda_f) sda_cnt <= '0;
            else if (sda_cnt == CNT_MAX) begin
                sda_f   <= sda_s[1];
                sda_cnt <= '0;
            end else sda_cnt <= sda_cnt + 1'b1;
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c;
    assign scl_rise = scl_f & ~scl_q;
    assign scl_fall = ~scl_f & scl_q;
    assign start_c  = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_c   = scl_f & scl_q & ~sda_q & sda_f;

    state_t     state, state_n;
    logic [2:0] bitcnt, bitcnt_n;
    logic [6:0] sr, sr_n;
    logic [7:0] ptr, ptr_n, wdata_n, shift_in;
    logic       phase, phase_n, rw, rw_n, sda_n, we_n, re_n, busy_n, addr_hit;

    assign shift_in = {sr, sda_f};
    assign addr_hit = (shift_in[7:1] == ADDR) && (shift_in[7:1] != 7'd0);
    assign reg_addr = ptr;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            bitcnt    <= 3'd0;
            sr        <= 7'd0;
            ptr       <= 8'd0;
            phase     <= 1'b0;
            rw        <= 1'b0;
            sda_o     <= 1'b1;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            reg_wdata <= 8'd0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bitcnt    <= bitcnt_n;
            sr        <= sr_n;
            ptr       <= ptr_n;
            phase     <= phase_n;
            rw        <= rw_n;
            sda_o     <= sda_n;
            reg_we    <= we_n;
            reg_re    <= re_n;
            reg_wdata <= wdata_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        sr_n     = sr;
        ptr_n    = ptr;
        phase_n  = phase;
        rw_n     = rw;
        sda_n    = sda_o;
        we_n     = 1'b0;
        re_n     = 1'b0;
        wdata_n  = reg_wdata;
        busy_n   = busy;
        if (reg_we) ptr_n = ptr + 8'd1;
        // Prefetch completes one cycle after the read strobe; the MSB goes out immediately.
        if (reg_re) begin
            ptr_n = ptr + 8'd1;
            sr_n  = reg_rdata[6:0];
            sda_n = reg_rdata[7];
        end
        if (start_c) begin
            state_n  = S_ADDR;
            bitcnt_n = 3'd0;
            phase_n  = 1'b0;
            sda_n    = 1'b1;
            busy_n   = 1'b0;
        end else if (stop_c) begin
            state_n = S_IDLE;
            phase_n = 1'b0;
            sda_n   = 1'b1;
            busy_n  = 1'b0;
        end else begin
            case (state)
                S_ADDR: if (scl_rise) begin
                    sr_n     = shift_in[6:0];
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        if (addr_hit) begin
                            state_n = S_ADDR_ACK;
                            busy_n  = 1'b1;
                            rw_n    = sda_f;
                        end else state_n = S_IGNORE;
                    end
                end
                S_PTR: if (scl_rise) begin
                    sr_n     = shift_in[6:0];
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        ptr_n   = shift_in;
                        state_n = S_PTR_ACK;
                    end
                end
                S_WDATA: if (scl_rise) begin
                    sr_n     = shift_in[6:0];
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        we_n    = 1'b1;
                        wdata_n = shift_in;
                        state_n = S_WDATA_ACK;
                    end
                end
                // phase=0: first fall starts the ACK bit; phase=1: second fall ends it.
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                    if (!phase) begin
                        sda_n   = 1'b0;
                        phase_n = 1'b1;
                    end else begin
                        phase_n  = 1'b0;
                        bitcnt_n = 3'd0;
                        if (state == S_ADDR_ACK && rw) begin
                            re_n    = 1'b1;
                            state_n = S_RDATA;
                        end else begin
                            sda_n   = 1'b1;
                            state_n = (state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                        end
                    end
                end
                S_RDATA: if (scl_rise) begin
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_n = S_RACK;
                        phase_n = 1'b0;
                    end
                end else if (scl_fall) begin
                    sda_n = sr[6];
                    sr_n  = {sr[5:0], 1'b1};
                end
                S_RACK: if (scl_fall) begin
                    if (!phase) sda_n = 1'b1;
                    else begin
                        re_n     = 1'b1;
                        phase_n  = 1'b0;
                        bitcnt_n = 3'd0;
                        state_n  = S_RDATA;
                    end
                end else if (scl_rise) begin
                    if (sda_f) begin
                        state_n = S_IGNORE;
                        busy_n  = 1'b0;
                    end else phase_n = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: a bit-banged controller drives the bus, a transaction-level model predicts
// register strobes and read data, and one compare process scores everything.
module tb_i2c_target_regs;
    logic       sys_clk = 1'b0, sys_rst = 1'b1;
    logic       scl_m = 1'b1, sda_m = 1'b1, g_scl = 1'b0, g_sda = 1'b0;
    logic       scl_i, sda_i, sda_o, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic [7:0] mem [256];

    always #5 sys_clk = ~sys_clk;
    assign scl_i     = scl_m | g_scl;
    assign sda_i     = sda_m & sda_o & ~g_sda;
    assign reg_rdata = mem[reg_addr];

    i2c_target_regs #(.ADDR(7'h42), .FILT_LEN(3)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .scl_i(scl_i), .sda_i(sda_i), .sda_o(sda_o),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy));

    int         checks = 0, errors = 0;
    logic [7:0] ew_a [64], ew_d [64], er_a [64];
    int         ew_n = 0, er_n = 0, wi = 0, ri = 0;
    int         req_id = 0, seen_id = 0;
    string      req_tag;
    logic [7:0] req_got, req_exp;
    logic       quiet = 1'b0;
    logic [7:0] model_ptr = 8'h00;

    // Single scoring point: posted point checks plus per-cycle strobe checks against the model tables.
    always @(negedge sys_clk) begin
        if (req_id != seen_id) begin
            seen_id = req_id;
            checks++;
            if (req_got !== req_exp) begin
                errors++;
                $display("FAIL %s: got %02h expected %02h", req_tag, req_got, req_exp);
            end
        end
        if (!sys_rst) begin
            checks++;
            if (reg_we && reg_re) begin
                errors++;
                $display("FAIL we_re_overlap: got we=1 re=1 expected never both");
            end
            if (reg_we) begin
                checks++;
                if (wi >= ew_n) begin
                    errors++;
                    $display("FAIL unexpected_we: got addr %02h data %02h expected no write", reg_addr, reg_wdata);
                end else begin
                    if (reg_addr !== ew_a[wi] || reg_wdata !== ew_d[wi]) begin
                        errors++;
                        $display("FAIL write: got %02h/%02h expected %02h/%02h", reg_addr, reg_wdata, ew_a[wi], ew_d[wi]);
                    end
                    wi++;
                end
            end
            if (reg_re) begin
                checks++;
                if (ri >= er_n) begin
                    errors++;
                    $display("FAIL unexpected_re: got addr %02h expected no read", reg_addr);
                end else begin
                    if (reg_addr !== er_a[ri]) begin
                        errors++;
                        $display("FAIL read_addr: got %02h expected %02h", reg_addr, er_a[ri]);
                    end
                    ri++;
                end
            end
            if (quiet) begin
                checks++;
                if (sda_o !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL quiet: got sda_o=%0b busy=%0b expected 1/0", sda_o, busy);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic post(input string tag, input logic [7:0] got, input logic [7:0] exp);
        req_tag = tag; req_got = got; req_exp = exp; req_id++;
        @(negedge sys_clk); #1;
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [7:0] d);
        ew_a[ew_n] = a; ew_d[ew_n] = d; ew_n++;
    endtask

    task automatic exp_rd(input logic [7:0] a);
        er_a[er_n] = a; er_n++;
    endtask

    // kind 1: one-cycle SDA low pulse while SCL high; kind 2: one-cycle SCL pulse while SCL low.
    task automatic xfer_bit(input logic b, input int kind, output logic got);
        cyc(8); sda_m = b; cyc(6);
        if (kind == 2) begin g_scl = 1'b1; cyc(1); g_scl = 1'b0; end else cyc(1);
        cyc(5); scl_m = 1'b1; cyc(6);
        if (kind == 1) begin g_sda = 1'b1; cyc(1); g_sda = 1'b0; end else cyc(1);
        cyc(3); got = sda_i; cyc(10); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gb, input int gk, output logic ack);
        logic dmy;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], (i == gb) ? gk : 0, dmy);
        xfer_bit(1'b1, 0, ack);
    endtask

    task automatic recv_byte(input logic ack_val, output logic [7:0] d);
        logic dmy;
        for (int i = 7; i >= 0; i--) xfer_bit(1'b1, 0, d[i]);
        xfer_bit(ack_val, 0, dmy);
    endtask

    task automatic start_c;
        sda_m = 1'b1; cyc(12); scl_m = 1'b1; cyc(10); sda_m = 1'b0; cyc(10); scl_m = 1'b0;
    endtask

    task automatic stop_c;
        sda_m = 1'b0; cyc(10); scl_m = 1'b1; cyc(10); sda_m = 1'b1; cyc(10);
    endtask

    // Model: a matched write sets the pointer, then each data byte lands at pointer+i (8-bit wrap).
    task automatic wr_txn(input logic [7:0] p, input logic [7:0] d0, input logic [7:0] d1, input int n,
                          input int pgb, input int pgk, input int dgb, input int dgk);
        logic a;
        start_c;
        send_byte(8'h84, -1, 0, a); post("addr_ack", {7'b0, a}, 8'h00);
        post("busy_mid", {7'b0, busy}, 8'h01);
        send_byte(p, pgb, pgk, a); post("ptr_ack", {7'b0, a}, 8'h00);
        model_ptr = p;
        exp_wr(model_ptr, d0); model_ptr = model_ptr + 8'd1;
        send_byte(d0, dgb, dgk, a); post("data0_ack", {7'b0, a}, 8'h00);
        if (n > 1) begin
            exp_wr(model_ptr, d1); model_ptr = model_ptr + 8'd1;
            send_byte(d1, -1, 0, a); post("data1_ack", {7'b0, a}, 8'h00);
        end
        stop_c;
        post("busy_after_stop", {7'b0, busy}, 8'h00);
        post("we_count", 8'(wi), 8'(ew_n));
    endtask

    initial begin
        logic       a;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'hC3; mem[8'h11] = 8'h3C; mem[8'h20] = 8'h00;

        cyc(4);
        post("rst_sda_o", {7'b0, sda_o}, 8'h01);
        post("rst_we", {7'b0, reg_we}, 8'h00);
        post("rst_re", {7'b0, reg_re}, 8'h00);
        post("rst_busy", {7'b0, busy}, 8'h00);
        post("rst_addr", reg_addr, 8'h00);
        post("rst_wdata", reg_wdata, 8'h00);
        sys_rst = 1'b0; cyc(30);

        // Plain two-byte write
        wr_txn(8'h10, 8'hA5, 8'h5A, 2, -1, 0, -1, 0);
        post("ptr_after_write", reg_addr, 8'h12);

        // Pointer write, repeated START, two-byte read ending in NACK
        start_c;
        send_byte(8'h84, -1, 0, a); post("rd_addr_w_ack", {7'b0, a}, 8'h00);
        send_byte(8'h10, -1, 0, a); post("rd_ptr_ack", {7'b0, a}, 8'h00);
        model_ptr = 8'h10;
        start_c;
        exp_rd(model_ptr); exp_rd(model_ptr + 8'd1);
        send_byte(8'h85, -1, 0, a); post("rd_addr_r_ack", {7'b0, a}, 8'h00);
        recv_byte(1'b0, d);
        post("rd_byte0_model", d, mem[model_ptr]); post("rd_byte0", d, 8'hC3);
        model_ptr = model_ptr + 8'd1;
        recv_byte(1'b1, d);
        post("rd_byte1_model", d, mem[model_ptr]); post("rd_byte1", d, 8'h3C);
        model_ptr = model_ptr + 8'd1;
        cyc(10);
        post("sda_released_after_nack", {7'b0, sda_o}, 8'h01);
        stop_c;
        post("re_count", 8'(ri), 8'(er_n));
        post("ptr_after_read", reg_addr, model_ptr);

        // Address mismatch: bus must stay untouched
        quiet = 1'b1;
        start_c;
        send_byte(8'h86, -1, 0, a); post("mismatch_addr_nack", {7'b0, a}, 8'h01);
        send_byte(8'h00, -1, 0, a); post("mismatch_data_nack", {7'b0, a}, 8'h01);
        stop_c;
        cyc(5);
        quiet = 1'b0;
        post("mismatch_we_count", 8'(wi), 8'(ew_n));

        // Pointer wraps 0xFF -> 0x00
        wr_txn(8'hFF, 8'h11, 8'h22, 2, -1, 0, -1, 0);
        post("ptr_after_wrap", reg_addr, 8'h01);

        // Sub-filter glitches on SCL (pointer byte) and SDA (data byte)
        wr_txn(8'h30, 8'hA5, 8'h00, 1, 4, 2, 7, 1);
        post("ptr_after_glitch", reg_addr, 8'h31);

        // Reset while driving a read zero, then a clean write
        start_c;
        send_byte(8'h84, -1, 0, a); post("rst_txn_addr_ack", {7'b0, a}, 8'h00);
        send_byte(8'h20, -1, 0, a); post("rst_txn_ptr_ack", {7'b0, a}, 8'h00);
        start_c;
        exp_rd(8'h20);
        send_byte(8'h85, -1, 0, a); post("rst_txn_rd_ack", {7'b0, a}, 8'h00);
        cyc(10);
        post("rdata_msb_low", {7'b0, sda_o}, {7'b0, mem[8'h20][7]});
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        post("sda_after_rst", {7'b0, sda_o}, 8'h01);
        post("busy_after_rst", {7'b0, busy}, 8'h00);
        post("addr_after_rst", reg_addr, 8'h00);
        cyc(2);
        sys_rst = 1'b0;
        model_ptr = 8'h00;
        sda_m = 1'b1; scl_m = 1'b1; cyc(30);
        wr_txn(8'h05, 8'h77, 8'h00, 1, -1, 0, -1, 0);
        post("ptr_after_rst_write", reg_addr, 8'h06);

        post("we_total", 8'(wi), 8'(ew_n));
        post("re_total", 8'(ri), 8'(er_n));
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
